// File: rtl/sw_input_pkg.sv
// Shared types and constants for the switch input port.
package sw_input_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } rd_state_t;

    localparam int unsigned FIFO_DEPTH          = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 100000;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus prescaled two-sample debounce filter, one per switch bit.
module sw_debounce
    import sw_input_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_BITS       = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam logic [TICK_BITS-1:0] LP_LAST = TICK_BITS'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]     r_sync1;
    logic [WIDTH-1:0]     r_sync2;
    logic [WIDTH-1:0]     r_samp;
    logic [WIDTH-1:0]     r_stable;
    logic [TICK_BITS-1:0] r_tick_cnt;
    logic                 w_tick;
    logic [WIDTH-1:0]     w_agree;

    assign w_tick  = (r_tick_cnt == LP_LAST);
    // A bit is accepted only when two consecutive tick samples agree.
    assign w_agree = ~(r_sync2 ^ r_samp);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_samp     <= '0;
            r_stable   <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= raw;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_samp   <= r_sync2;
                r_stable <= (r_stable & ~w_agree) | (r_sync2 & w_agree);
            end
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/sw_input_port.sv
// Debounced switch entry with enter-key commit and CPU req/ack read port.
// Define SW_INPUT_FIFO_EN to replace the single hold register with a 4-entry FIFO.
module sw_input_port
    import sw_input_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_BITS       = 17,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   SW,
    input  logic                  cpu_rd_req,
    output logic                  cpu_rd_ack,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  data_valid,
    output logic                  overrun,
    output logic [SW_WIDTH-1:0]   sw_stable
);

    localparam int unsigned VW  = SW_WIDTH - 1;
    localparam int unsigned PAD = DATA_WIDTH - VW;

    logic [SW_WIDTH-1:0]   w_stable;
    logic                  r_enter_prev;
    logic                  w_commit;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_dv;
    logic [VW-1:0]         w_head;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_overrun;
    rd_state_t             r_state;
    rd_state_t             w_next;

    sw_debounce #(
        .WIDTH          (SW_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TICK_BITS      (TICK_BITS)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .raw   (SW),
        .stable(w_stable)
    );

    assign w_commit = w_stable[SW_WIDTH-1] & ~r_enter_prev;
    assign w_pop    = (r_state == ACK);
    // A pop in the same cycle frees the slot, so that commit is accepted, not overrun.
    assign w_push   = w_commit & (~w_full | w_pop);

`ifdef SW_INPUT_FIFO_EN
    logic [VW-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]    r_rd_ptr;
    logic [1:0]    r_wr_ptr;
    logic [2:0]    r_count;

    assign w_full = (r_count == 3'(FIFO_DEPTH));
    assign w_dv   = (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_stable[SW_WIDTH-2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [VW-1:0] r_hold;
    logic          r_valid;

    assign w_full = r_valid;
    assign w_dv   = r_valid;
    assign w_head = r_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_hold  <= w_stable[SW_WIDTH-2:0];
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (cpu_rd_req) w_next = w_dv ? ACK : WAIT;
            WAIT: begin
                if (w_dv)             w_next = ACK;
                else if (!cpu_rd_req) w_next = IDLE;
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read data is captured on entry to ACK so it is stable for the whole ack cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_ack        <= 1'b0;
            r_data       <= '0;
            r_enter_prev <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_ack        <= (w_next == ACK);
            r_enter_prev <= w_stable[SW_WIDTH-1];
            if (w_next == ACK) r_data <= {{PAD{1'b0}}, w_head};
            if (w_commit && w_full && !w_pop) r_overrun <= 1'b1;
        end
    end

    assign cpu_rd_ack  = r_ack;
    assign cpu_rd_data = r_data;
    assign data_valid  = w_dv;
    assign overrun     = r_overrun;
    assign sw_stable   = w_stable;

endmodule

// File: tb/tb_sw_input_port.sv
// Scoreboard bench for sw_input_port: committed values queue, monitor pops on each ack.
module tb_sw_input_port;

`ifdef SW_INPUT_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] SW = '0;
    logic        cpu_rd_req = 1'b0;
    logic        cpu_rd_ack;
    logic [31:0] cpu_rd_data;
    logic        data_valid;
    logic        overrun;
    logic [15:0] sw_stable;

    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;
    logic [14:0] exp_q[$];
    logic        exp_overrun = 1'b0;

    sw_input_port #(
        .SW_WIDTH       (16),
        .DEBOUNCE_CYCLES(4),
        .TICK_BITS      (3),
        .DATA_WIDTH     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SW         (SW),
        .cpu_rd_req (cpu_rd_req),
        .cpu_rd_ack (cpu_rd_ack),
        .cpu_rd_data(cpu_rd_data),
        .data_valid (data_valid),
        .overrun    (overrun),
        .sw_stable  (sw_stable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && cpu_rd_ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack data %h expected no ack", cpu_rd_data);
            end else begin
                chk("ack_data", cpu_rd_data, {17'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_stable(input logic [15:0] want);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sw_stable == want) break;
        end
        chk("sw_stable_settle", 32'(sw_stable), 32'(want));
    endtask

    task automatic enter(input logic [14:0] v);
        SW = {1'b0, v};
        wait_stable({1'b0, v});
        SW = {1'b1, v};
        wait_stable({1'b1, v});
        if (exp_q.size() < CAP) exp_q.push_back(v);
        else exp_overrun = 1'b1;
        step(1);
        chk("dv_after_enter", 32'(data_valid), 32'd1);
        SW = {1'b0, v};
        wait_stable({1'b0, v});
    endtask

    task automatic read_now();
        int lat;
        lat = 0;
        cpu_rd_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            lat++;
            if (cpu_rd_ack) break;
        end
        cpu_rd_req = 1'b0;
        chk("ack_latency", 32'(lat), 32'd1);
        step(1);
        chk("dv_after_read", 32'(data_valid), 32'(exp_q.size() != 0));
    endtask

    task automatic read_all();
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) read_now();
    endtask

    initial begin
        int   changes;
        int   acks0;
        logic prev;
        logic got;

        // Reset with all switches up
        SW = 16'hFFFF;
        rst = 1'b0;
        step(3);
        chk("rst_ack", 32'(cpu_rd_ack), 32'd0);
        chk("rst_data", cpu_rd_data, 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_stable", 32'(sw_stable), 32'd0);
        rst = 1'b1;
        wait_stable(16'hFFFF);
        exp_q.push_back(15'h7FFF);
        step(1);
        chk("dv_after_reset_commit", 32'(data_valid), 32'd1);
        SW = 16'h7FFF;
        wait_stable(16'h7FFF);
        read_now();

        // Bounce on bit 0
        SW = 16'h0000;
        wait_stable(16'h0000);
        acks0 = ack_cnt;
        changes = 0;
        prev = sw_stable[0];
        for (int i = 0; i < 40; i++) begin
            if (i < 20) SW[0] = ~SW[0];
            else SW[0] = 1'b1;
            step(1);
            if (sw_stable[0] != prev) begin
                changes++;
                prev = sw_stable[0];
            end
        end
        chk("bounce_changes", 32'(changes), 32'd1);
        chk("bounce_final", 32'(sw_stable[0]), 32'd1);
        chk("bounce_no_commit", 32'(data_valid), 32'd0);
        chk("bounce_no_ack", 32'(ack_cnt - acks0), 32'd0);

        // Basic read
        enter(15'h1234);
        read_now();

        // Request before data
        cpu_rd_req = 1'b1;
        acks0 = ack_cnt;
        step(10);
        chk("wait_no_ack", 32'(ack_cnt - acks0), 32'd0);
        chk("wait_dv", 32'(data_valid), 32'd0);
        got = 1'b0;
        fork
            enter(15'h7FFF);
            begin
                for (int i = 0; i < 60; i++) begin
                    step(1);
                    if (cpu_rd_ack) begin
                        got = 1'b1;
                        break;
                    end
                end
                cpu_rd_req = 1'b0;
            end
        join
        chk("wait_ack_seen", 32'(got), 32'd1);
        chk("wait_dv_after", 32'(data_valid), 32'(exp_q.size() != 0));

        // Withdraw
        acks0 = ack_cnt;
        cpu_rd_req = 1'b1;
        step(5);
        cpu_rd_req = 1'b0;
        step(5);
        enter(15'h0ABC);
        step(10);
        chk("withdraw_no_ack", 32'(ack_cnt - acks0), 32'd0);
        chk("withdraw_dv", 32'(data_valid), 32'd1);
        read_now();

        // Overrun / FIFO ordering
        enter(15'h0011);
        enter(15'h0022);
        chk("overrun_two", 32'(overrun), 32'(exp_overrun));
        read_all();
        for (int i = 0; i <= CAP; i++) enter(15'($urandom));
        chk("overrun_full", 32'(overrun), 32'(exp_overrun));
        read_all();

        // Random traffic
        for (int it = 0; it < 5; it++) begin
            int n;
            n = int'($urandom_range(1, CAP));
            for (int j = 0; j < n; j++) enter(15'($urandom));
            read_all();
        end
        chk("overrun_end", 32'(overrun), 32'(exp_overrun));
        chk("dv_end", 32'(data_valid), 32'(exp_q.size() != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
